// File: rtl/pixel_frame_feeder.sv
// pixel_frame_feeder
//
// Collects one full RGB frame from a camera-side valid/ready pixel stream into an
// internal frame buffer, then replays it as a gap-free burst (one pixel per clock)
// towards the classification network. The network has no backpressure, so the
// whole frame is buffered before the burst starts.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   pix_in      input pixel, R[23:16] G[15:8] B[7:0]
//   pix_valid   pix_in valid
//   pix_sof     start-of-frame marker, qualified by pix_valid
//   pix_ready   feeder accepts pix_in this cycle (registered)
//   d_out       pixel to network d_in (registered)
//   conv_start  burst-valid to network, high for exactly one frame (registered)
//   frame_cnt   frames streamed, wraps 255->0
//   sof_err     sticky SOF-misalignment flag
//
// Optional feature macro: FEEDER_SOF_RESYNC_EN
//   defined   : an accepted pix_sof on a non-first pixel restarts the frame at
//               address 0 and sets sof_err (sticky until reset).
//   undefined : pix_sof is ignored, sof_err is always 0, frame boundary is purely
//               the pixel count.

module pixel_frame_feeder #(
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [DATA_W-1:0] d_out,
  output logic              conv_start,
  output logic [7:0]        frame_cnt,
  output logic              sof_err
);

  localparam int unsigned FRAME_PIXELS = IMG_W * IMG_H;
  localparam int unsigned AW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AW-1:0] LastWrAddr = AW'(FRAME_PIXELS - 1);
  // rd_addr runs one past the frame: at FRAME_PIXELS the last pixel is still in the
  // read register waiting to be emitted, at FRAME_PIXELS+1 the burst is complete.
  localparam logic [AW:0]   RdEnd      = (AW + 1)'(FRAME_PIXELS);
  localparam logic [AW:0]   RdDone     = (AW + 1)'(FRAME_PIXELS + 1);
  localparam logic [GW-1:0] GapLast    = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StWrite,
    StPrime,
    StStream,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW:0]       rd_addr_q, rd_addr_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              conv_start_q, conv_start_d;
  logic              pix_ready_q, pix_ready_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              sof_err_q, sof_err_d;

  // Frame buffer: one write port, one synchronous read port.
  logic [DATA_W-1:0] mem [FRAME_PIXELS];
  logic [DATA_W-1:0] ram_rd_q;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic              mem_re;
  logic [AW-1:0]     mem_raddr;

  logic accept;
  logic resync;

  // pix_ready_q is only ever high in StWrite.
  assign accept = pix_valid & pix_ready_q;

`ifdef FEEDER_SOF_RESYNC_EN
  assign resync = accept & pix_sof & (wr_addr_q != '0);
`else
  assign resync = 1'b0;
  logic unused_pix_sof;
  assign unused_pix_sof = pix_sof;
`endif

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    gap_cnt_d    = gap_cnt_q;
    d_out_d      = d_out_q;
    conv_start_d = conv_start_q;
    pix_ready_d  = pix_ready_q;
    frame_cnt_d  = frame_cnt_q;
    sof_err_d    = sof_err_q | resync;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr_q;
    mem_re       = 1'b0;
    mem_raddr    = '0;

    unique case (state_q)
      StWrite: begin
        pix_ready_d  = 1'b1;
        conv_start_d = 1'b0;
        if (accept) begin
          mem_we = 1'b1;
          if (resync) begin
            // Misaligned SOF: this pixel becomes pixel 0 of a fresh frame.
            mem_waddr = '0;
            wr_addr_d = AW'(1);
          end else if (wr_addr_q == LastWrAddr) begin
            wr_addr_d   = '0;
            pix_ready_d = 1'b0;
            state_d     = StPrime;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end

      StPrime: begin
        mem_re    = 1'b1;
        mem_raddr = '0;
        rd_addr_d = (AW + 1)'(1);
        state_d   = StStream;
      end

      StStream: begin
        if (rd_addr_q == RdDone) begin
          conv_start_d = 1'b0;
          d_out_d      = '0;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          gap_cnt_d    = '0;
          rd_addr_d    = '0;
          state_d      = StGap;
        end else begin
          d_out_d      = ram_rd_q;
          conv_start_d = 1'b1;
          rd_addr_d    = rd_addr_q + (AW + 1)'(1);
          if (rd_addr_q < RdEnd) begin
            mem_re    = 1'b1;
            mem_raddr = rd_addr_q[AW-1:0];
          end
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          pix_ready_d = 1'b1;
          state_d     = StWrite;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = StWrite;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StWrite;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      gap_cnt_q    <= '0;
      d_out_q      <= '0;
      conv_start_q <= 1'b0;
      pix_ready_q  <= 1'b0;
      frame_cnt_q  <= '0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      gap_cnt_q    <= gap_cnt_d;
      d_out_q      <= d_out_d;
      conv_start_q <= conv_start_d;
      pix_ready_q  <= pix_ready_d;
      frame_cnt_q  <= frame_cnt_d;
      sof_err_q    <= sof_err_d;
    end
  end

  // RAM contents are not reset; a partial frame after reset is simply overwritten.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= pix_in;
    end
    if (mem_re) begin
      ram_rd_q <= mem[mem_raddr];
    end
  end

  assign pix_ready  = pix_ready_q;
  assign d_out      = d_out_q;
  assign conv_start = conv_start_q;
  assign frame_cnt  = frame_cnt_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Testbench for pixel_frame_feeder (4x4 frame, 4 gap cycles).
// A queue-based reference model collects accepted pixels into frames, derives the
// expected burst contents and timing, and checks them against the DUT outputs.

module tb_pixel_frame_feeder;

  localparam int unsigned IMG_W      = 4;
  localparam int unsigned IMG_H      = 4;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int          NPIX       = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              pix_ready;
  logic [DATA_W-1:0] d_out;
  logic              conv_start;
  logic [7:0]        frame_cnt;
  logic              sof_err;

  pixel_frame_feeder #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .d_out      (d_out),
    .conv_start (conv_start),
    .frame_cnt  (frame_cnt),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  logic [DATA_W-1:0] frame_q[$];
  logic [DATA_W-1:0] burst_q[$];
  bit                pend;
  bit                in_burst;
  bit                gap_wait;
  bit                acc_flag;
  int                pend_edge;
  int                burst_idx;
  int                ready_due;
  logic [7:0]        exp_fcnt;
  bit                exp_sof_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    frame_q.delete();
    burst_q.delete();
    pend        = 1'b0;
    in_burst    = 1'b0;
    gap_wait    = 1'b0;
    burst_idx   = 0;
    exp_fcnt    = '0;
    exp_sof_err = 1'b0;
  endtask

  // Called at the falling edge; cyc = rising edges seen so far.
  task automatic monitor();
    acc_flag = 1'b0;
    if (conv_start) begin
      if (!in_burst) begin
        if (pend) check_eq("burst_start", cyc, pend_edge + 2);
        else      check_eq("burst_unexpected", conv_start, 0);
        in_burst  = 1'b1;
        burst_idx = 0;
      end
      if (burst_idx < burst_q.size()) check_eq("d_out", d_out, burst_q[burst_idx]);
      else                            check_eq("burst_len", conv_start, 0);
      burst_idx++;
      check_eq("ready_in_burst", pix_ready, 0);
    end else if (in_burst) begin
      check_eq("burst_len", burst_idx, NPIX);
      check_eq("d_out_idle", d_out, 0);
      exp_fcnt++;
      check_eq("frame_cnt", frame_cnt, exp_fcnt);
      check_eq("sof_err", sof_err, exp_sof_err);
      in_burst  = 1'b0;
      pend      = 1'b0;
      gap_wait  = 1'b1;
      ready_due = cyc + GAP_CYCLES;
    end else if (pend && cyc >= pend_edge + 2) begin
      check_eq("burst_start", conv_start, 1);
      pend = 1'b0;
    end else if (pend) begin
      check_eq("ready_prime", pix_ready, 0);
    end

    if (gap_wait) begin
      if (cyc < ready_due) begin
        check_eq("ready_gap", pix_ready, 0);
      end else begin
        check_eq("ready_return", pix_ready, 1);
        gap_wait = 1'b0;
      end
    end

    if (pix_valid && pix_ready) begin
      acc_flag = 1'b1;
`ifdef FEEDER_SOF_RESYNC_EN
      if (pix_sof && frame_q.size() != 0) begin
        frame_q.delete();
        exp_sof_err = 1'b1;
      end
`endif
      frame_q.push_back(pix_in);
      if (frame_q.size() == NPIX) begin
        burst_q   = frame_q;
        frame_q.delete();
        pend      = 1'b1;
        pend_edge = cyc + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    rst       = 1'b0;
    #1;
    check_eq("rst_conv_start", conv_start, 0);
    check_eq("rst_d_out", d_out, 0);
    check_eq("rst_pix_ready", pix_ready, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_sof_err", sof_err, 0);
    model_clear();
    repeat (3) step();
    rst       = 1'b1;
    gap_wait  = 1'b1;
    ready_due = cyc + 1;
  endtask

  task automatic send_pixel(input logic [DATA_W-1:0] val, input logic sof);
    int n;
    pix_in    = val;
    pix_sof   = sof;
    pix_valid = 1'b1;
    n         = 0;
    acc_flag  = 1'b0;
    while (!acc_flag && n < 200) begin
      step();
      n++;
    end
    if (!acc_flag) check_eq("accept_timeout", acc_flag, 1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_rand_frame(input int max_gap);
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(DATA_W'($urandom()), 1'b0);
      repeat ($urandom_range(max_gap, 0)) step();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((in_burst || pend || gap_wait) && n < 300) begin
      step();
      n++;
    end
    if (in_burst || pend || gap_wait) check_eq("idle_timeout", in_burst | pend | gap_wait, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #2;
    do_reset();
    repeat (3) step();

    // Back-to-back frame 0x000001..0x000010
    for (int i = 0; i < NPIX; i++) send_pixel(DATA_W'(i + 1), 1'b0);
    wait_idle();

    // Same frame, valid toggled every other cycle
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(DATA_W'(i + 1), 1'b0);
      step();
    end
    wait_idle();

    // Valid held through PRIME/STREAM/GAP with 0xFFFFFF; it must open the next frame
    send_rand_frame(0);
    send_pixel(24'hFFFFFF, 1'b0);
    for (int i = 1; i < NPIX; i++) send_pixel(DATA_W'($urandom()), 1'b0);
    wait_idle();

    // SOF on pixel 5
    for (int i = 0; i < 5; i++) send_pixel(DATA_W'($urandom()), 1'b0);
    send_pixel(24'hAA0000, 1'b1);
    for (int i = 0; i < NPIX - 1; i++) send_pixel(DATA_W'($urandom()), 1'b0);
    while (frame_q.size() != 0) send_pixel(DATA_W'($urandom()), 1'b0);
    wait_idle();

    // Reset during burst cycle 7
    send_rand_frame(1);
    n = 0;
    while (!(in_burst && burst_idx == 7) && n < 100) begin
      step();
      n++;
    end
    check_eq("abort_reached", burst_idx, 7);
    do_reset();
    send_rand_frame(2);
    wait_idle();

    // Enough frames to wrap frame_cnt through 255->0
    for (int f = 0; f < 256; f++) begin
      send_rand_frame(1);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
